// File: rtl/lapido_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lapido_pkg
//  Description : Shared constants for the lapido core datapath blocks:
//                machine word width, arb_mux operating modes and a helper
//                for select/index widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package lapido_pkg;

    localparam int WORD_WIDTH   = 32;

    // arb_mux operating modes
    localparam int MUX_MODE_SEL = 0;  // channel chosen by external select
    localparam int MUX_MODE_RR  = 1;  // channel chosen by round-robin arbiter

    // Width of an index able to address n channels (never below one bit)
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : lapido_pkg
`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Picks the first
//                requesting channel at or after ptr, wrapping at NUM_IN,
//                and reports it both one-hot and as an encoded index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import lapido_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  idx,
    output logic              any_req
);

    int w_pos;

    // Walk the channels starting at ptr; the first requester found wins
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_pos = (int'(ptr) + k) % NUM_IN;
            if (!any_req && req[w_pos]) begin
                any_req      = 1'b1;
                grant[w_pos] = 1'b1;
                idx          = SEL_W'(w_pos);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : N-input registered multiplexer with valid/ready handshakes
//                on every input and on the output. The channel is chosen by
//                an external select (MODE 0) or by a round-robin arbiter
//                (MODE 1). A one-entry output register gives 1 word/cycle
//                with back-pressure and no in_data -> out_data comb path.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
    import lapido_pkg::*;
#(
    parameter  int DATA_WIDTH = WORD_WIDTH,
    parameter  int NUM_IN     = 4,
    parameter  int MODE       = MUX_MODE_SEL,
    localparam int SEL_W      = sel_width(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [SEL_W-1:0]             sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_src
);

    logic                  w_load;        // output register may take a word
    logic                  w_cand_ok;     // a legal candidate channel exists
    logic [SEL_W-1:0]      w_cand;        // candidate channel index
    logic                  w_cand_valid;  // in_valid of the candidate
    logic [DATA_WIDTH-1:0] w_cand_data;   // in_data of the candidate
    logic                  w_in_xfer;     // input handshake completes
    logic [NUM_IN-1:0]     w_ready;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]      r_out_src;

    // Register is empty or drains this cycle, so it can accept a new word
    assign w_load = !r_out_valid || out_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0]  r_ptr;
            logic [NUM_IN-1:0] w_grant;
            logic [SEL_W-1:0]  w_idx;
            logic              w_any;

            rr_arbiter #(
                .NUM_IN (NUM_IN)
            ) u_rr_arbiter (
                .req     (in_valid),
                .ptr     (r_ptr),
                .grant   (w_grant),
                .idx     (w_idx),
                .any_req (w_any)
            );

            assign w_cand    = w_idx;
            assign w_cand_ok = w_any;
            assign w_ready   = w_grant & {NUM_IN{w_load && !rst}};

            // Pointer moves just past the channel that was served; stalls hold it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_in_xfer) begin
                    r_ptr <= (w_cand == SEL_W'(NUM_IN - 1)) ? '0 : w_cand + 1'b1;
                end
            end
        end else begin : g_sel
            // Out-of-range select values grant nothing
            assign w_cand    = sel;
            assign w_cand_ok = ({1'b0, sel} < (SEL_W + 1)'(NUM_IN));

            // Ready goes to the selected channel only, independent of its valid
            always_comb begin
                w_ready = '0;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (w_cand == SEL_W'(i)) begin
                        w_ready[i] = w_cand_ok && w_load && !rst;
                    end
                end
            end
        end
    endgenerate

    // Route the candidate channel's data and valid toward the output register
    always_comb begin
        w_cand_data  = '0;
        w_cand_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_cand == SEL_W'(i)) begin
                w_cand_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_cand_valid = in_valid[i];
            end
        end
    end

    assign w_in_xfer = w_cand_ok && w_load && w_cand_valid;

    // One-entry output register: load replaces, drain empties, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_cand_data;
            r_out_src   <= w_cand;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule : arb_mux
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux
//  Description : Self-checking bench for arb_mux. Three instances:
//                dut0 = select mode, 4 inputs; dut1 = round-robin, 4 inputs;
//                dut2 = select mode, 3 inputs. A reference model predicts
//                in_ready and pushes expected words into per-instance
//                scoreboards; a monitor pops them as words leave the DUTs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

    typedef struct {
        logic [31:0] d;
        int          src;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] data [3][4];
    logic [3:0]  vld  [3];
    logic [1:0]  sel  [3];
    logic        ordy [3];

    logic [3:0]  rdy   [3];
    logic [31:0] odata [3];
    logic        ovld  [3];
    logic [1:0]  osrc  [3];

    logic [3:0]  rdy_0, rdy_1;
    logic [2:0]  rdy_2;
    logic [31:0] odata_0, odata_1, odata_2;
    logic        ovld_0, ovld_1, ovld_2;
    logic [1:0]  osrc_0, osrc_1, osrc_2;

    exp_t        sb [3][$];
    bit          m_full [3];
    int          m_ptr  [3];
    int          n_cmp;
    int          n_bad;

    arb_mux #(.DATA_WIDTH(32), .NUM_IN(4), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_data({data[0][3], data[0][2], data[0][1], data[0][0]}),
        .in_valid(vld[0]), .in_ready(rdy_0), .sel(sel[0]),
        .out_data(odata_0), .out_valid(ovld_0), .out_ready(ordy[0]), .out_src(osrc_0));

    arb_mux #(.DATA_WIDTH(32), .NUM_IN(4), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data({data[1][3], data[1][2], data[1][1], data[1][0]}),
        .in_valid(vld[1]), .in_ready(rdy_1), .sel(sel[1]),
        .out_data(odata_1), .out_valid(ovld_1), .out_ready(ordy[1]), .out_src(osrc_1));

    arb_mux #(.DATA_WIDTH(32), .NUM_IN(3), .MODE(0)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_data({data[2][2], data[2][1], data[2][0]}),
        .in_valid(vld[2][2:0]), .in_ready(rdy_2), .sel(sel[2]),
        .out_data(odata_2), .out_valid(ovld_2), .out_ready(ordy[2]), .out_src(osrc_2));

    assign rdy[0] = rdy_0;
    assign rdy[1] = rdy_1;
    assign rdy[2] = {1'b0, rdy_2};
    assign odata[0] = odata_0;
    assign odata[1] = odata_1;
    assign odata[2] = odata_2;
    assign ovld[0] = ovld_0;
    assign ovld[1] = ovld_1;
    assign ovld[2] = ovld_2;
    assign osrc[0] = osrc_0;
    assign osrc[1] = osrc_1;
    assign osrc[2] = osrc_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nin_of(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int mode_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) data[d][c] = $urandom;
            vld[d]  = (d == 2) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
            sel[d]  = 2'($urandom_range(0, 3));
            ordy[d] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Reference model: channel choice from the handshake rules, one-word register occupancy
    always @(negedge clk) begin
        int   n;
        int   cand;
        int   pos;
        bit   ok;
        bit   load;
        bit   xfer;
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            n = nin_of(d);
            if (rst) begin
                chk("in_ready_in_reset", d, 32'(rdy[d]), 32'd0);
                chk("out_valid_in_reset", d, 32'(ovld[d]), 32'd0);
                m_full[d] = 1'b0;
                m_ptr[d]  = 0;
                sb[d].delete();
            end else begin
                load = !m_full[d] || ordy[d];
                ok   = 1'b0;
                cand = 0;
                if (mode_of(d) == 0) begin
                    if (int'(sel[d]) < n) begin
                        ok   = 1'b1;
                        cand = int'(sel[d]);
                    end
                end else begin
                    for (int k = 0; k < n; k++) begin
                        pos = (m_ptr[d] + k) % n;
                        if (!ok && vld[d][pos]) begin
                            ok   = 1'b1;
                            cand = pos;
                        end
                    end
                end
                chk("in_ready", d, 32'(rdy[d]), (ok && load) ? (32'd1 << cand) : 32'd0);
                chk("out_valid", d, 32'(ovld[d]), 32'(m_full[d]));
                xfer      = ok && load && vld[d][cand];
                m_full[d] = xfer || (m_full[d] && !ordy[d]);
                if (xfer) begin
                    e.d   = data[d][cand];
                    e.src = cand;
                    sb[d].push_back(e);
                    if (mode_of(d) == 1) m_ptr[d] = (cand + 1) % n;
                end
            end
        end
    end

    // Monitor: compare every word the DUT presents against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (ovld[d]) begin
                    if (sb[d].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL out_word dut%0d: got word %0h src %0d, expected no word", d, odata[d], osrc[d]);
                    end else begin
                        e = sb[d][0];
                        chk("out_data", d, odata[d], e.d);
                        chk("out_src", d, 32'(osrc[d]), 32'(e.src));
                        if (ordy[d]) void'(sb[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) data[d][c] = 32'd0;
            vld[d]    = 4'd0;
            sel[d]    = 2'd0;
            ordy[d]   = 1'b0;
            m_full[d] = 1'b0;
            m_ptr[d]  = 0;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_out_data", d, odata[d], 32'd0);
            chk("reset_out_src", d, 32'(osrc[d]), 32'd0);
        end
        rst = 1'b0;

        // Select mode: channel 2 carries 0xDEADBEEF
        data[0][2] = 32'hDEADBEEF;
        sel[0]     = 2'd2;
        vld[0]     = 4'b0100;
        ordy[0]    = 1'b1;
        tick();
        chk("sel2_out_data", 0, odata[0], 32'hDEADBEEF);
        chk("sel2_out_src", 0, 32'(osrc[0]), 32'd2);
        chk("sel2_out_valid", 0, 32'(ovld[0]), 32'd1);

        // Back-pressure while select moves to channel 1: word must hold
        ordy[0]    = 1'b0;
        sel[0]     = 2'd1;
        vld[0]     = 4'b0010;
        data[0][1] = 32'h12345678;
        repeat (3) tick();
        chk("hold_out_data", 0, odata[0], 32'hDEADBEEF);
        chk("hold_out_src", 0, 32'(osrc[0]), 32'd2);
        ordy[0] = 1'b1;
        vld[0]  = 4'b0000;
        tick();

        // Round-robin: all four valid, output always ready
        vld[1]  = 4'hF;
        ordy[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) data[1][c] = $urandom;
            tick();
            chk("rr_full_rate_src", 1, 32'(osrc[1]), 32'(i % 4));
        end

        // Round-robin: move pointer to 1, then 1001 grants 3 before 0 across a stall
        vld[1] = 4'b0001;
        tick();
        vld[1] = 4'b1001;
        tick();
        chk("rr_wrap_first", 1, 32'(osrc[1]), 32'd3);
        ordy[1] = 1'b0;
        repeat (3) tick();
        chk("rr_stall_hold", 1, 32'(osrc[1]), 32'd3);
        ordy[1] = 1'b1;
        tick();
        chk("rr_wrap_second", 1, 32'(osrc[1]), 32'd0);
        vld[1] = 4'b0000;
        tick();

        // Three-input select mode: select 3 is out of range
        vld[2]  = 4'b0111;
        sel[2]  = 2'd3;
        ordy[2] = 1'b1;
        repeat (3) tick();
        chk("sel_out_of_range_valid", 2, 32'(ovld[2]), 32'd0);

        // Randomised traffic on all instances
        repeat (300) begin
            randomize_inputs();
            tick();
        end

        // Fill every output register under back-pressure, then reset mid-cycle
        for (int d = 0; d < 3; d++) begin
            vld[d]  = (d == 2) ? 4'b0111 : 4'b1111;
            sel[d]  = 2'd1;
            ordy[d] = 1'b0;
        end
        tick();
        tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async_rst_out_valid", d, 32'(ovld[d]), 32'd0);
            chk("async_rst_out_data", d, odata[d], 32'd0);
            chk("async_rst_in_ready", d, 32'(rdy[d]), 32'd0);
        end
        tick();
        rst     = 1'b0;
        vld[1]  = 4'hF;
        ordy[1] = 1'b1;
        tick();
        chk("rr_after_reset_first", 1, 32'(osrc[1]), 32'd0);
        tick();
        chk("rr_after_reset_second", 1, 32'(osrc[1]), 32'd1);

        // Drain everything; every expected word must have been seen
        for (int d = 0; d < 3; d++) begin
            vld[d]  = 4'd0;
            ordy[d] = 1'b1;
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("scoreboard_empty", d, 32'(sb[d].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_arb_mux
`default_nettype wire
